// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 16x-oversampled 8N1 UART receiver holding one byte, with overrun/framing flags
module uart_rx_unit #(
  parameter int CLK_DIV  = 326,
  parameter int OVERSAMP = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  input  logic       rx_clear,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       rx_busy
);
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
  localparam logic [3:0] T_MID = 4'(OVERSAMP / 2 - 1);
  localparam logic [3:0] T_END = 4'(OVERSAMP - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [1:0] sync;
  logic [DW-1:0] div;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sr;
  logic rx_s, tick;
  assign rx_s = sync[1];
  assign tick = (state != IDLE) && (div == DIV_END);
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) begin
      sync         <= 2'b11;
      state        <= IDLE;
      div          <= '0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      sr           <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      sync <= {sync[0], UART_RX};
      // divider phase restarts at every start-edge detection
      div <= (state == IDLE || tick) ? '0 : div + 1'b1;
      if (rx_clear) begin
        rx_valid     <= 1'b0;
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end
      if (tick) tick_cnt <= tick_cnt + 1'b1;
      case (state)
        IDLE:
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
            rx_busy  <= 1'b1;
          end
        START:
          if (tick && tick_cnt == T_MID) begin
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state    <= DATA;
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end
          end
        DATA:
          if (tick && tick_cnt == T_END) begin
            sr       <= {rx_s, sr[7:1]};
            tick_cnt <= '0;
            if (bit_cnt == 3'd7) state <= STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        STOP:
          // leave mid stop bit so a back-to-back start edge is still caught
          if (tick && tick_cnt == T_END) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
            if (!rx_s) rx_frame_err <= 1'b1;
            else if (!rx_valid || rx_clear) begin
              rx_data  <= sr;
              rx_valid <= 1'b1;
            end else rx_overrun <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: directed and random 8N1 frames checked against a frame-level receiver model
module tb_uart_rx_unit;
  localparam int DIV = 4;
  localparam int BIT = 64;
  logic sysclk = 1'b0, reset = 1'b0, UART_RX = 1'b1, rx_clear = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, rx_overrun, rx_frame_err, rx_busy;
  int n_vec = 0, n_err = 0, cyc = 0, t_start = 0, t_rise = -1, lat;
  logic prev_v = 1'b0;
  logic [7:0] m_data, b;
  logic m_valid, m_over, m_ferr, s;

  uart_rx_unit #(.CLK_DIV(DIV), .OVERSAMP(16)) dut (
    .sysclk(sysclk), .reset(reset), .UART_RX(UART_RX), .rx_clear(rx_clear),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_overrun(rx_overrun),
    .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;
  always @(negedge sysclk) begin
    if (rx_valid && !prev_v && t_rise < 0) t_rise = cyc;
    prev_v = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic busy);
    chk({tag, ".data"}, 32'(rx_data), 32'(m_data));
    chk({tag, ".valid"}, 32'(rx_valid), 32'(m_valid));
    chk({tag, ".overrun"}, 32'(rx_overrun), 32'(m_over));
    chk({tag, ".frame_err"}, 32'(rx_frame_err), 32'(m_ferr));
    chk({tag, ".busy"}, 32'(rx_busy), 32'(busy));
  endtask

  task automatic m_clear();
    m_valid = 1'b0;
    m_over  = 1'b0;
    m_ferr  = 1'b0;
  endtask

  task automatic m_reset();
    m_data = 8'h00;
    m_clear();
  endtask

  task automatic m_frame(input logic [7:0] d, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (!m_valid) begin
      m_data  = d;
      m_valid = 1'b1;
    end else m_over = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    t_start = cyc;
    UART_RX = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      idle(BIT);
    end
    UART_RX = stop;
    idle(BIT);
    UART_RX = 1'b1;
  endtask

  task automatic pulse_clear();
    rx_clear = 1'b1;
    idle(1);
    rx_clear = 1'b0;
  endtask

  initial begin
    m_reset();
    for (int i = 0; i < 20; i++) begin
      idle(1);
      UART_RX = 1'($urandom);
    end
    check_all("rst_hold", 1'b0);
    UART_RX = 1'b1;
    idle(1);
    reset = 1'b1;
    idle(10);
    check_all("rst_rel", 1'b0);

    t_rise = -1;
    send_frame(8'hA5, 1'b1);
    m_frame(8'hA5, 1'b1);
    idle(48);
    check_all("a5", 1'b0);
    lat = (t_rise < 0) ? -1 : t_rise - t_start;
    chk("a5.latency", 32'((lat >= 600 && lat <= 616) ? 608 : lat), 32'd608);
    pulse_clear();
    m_clear();
    idle(2);
    check_all("a5.clr", 1'b0);

    UART_RX = 1'b0;
    idle(10);
    chk("glitch.busy", 32'(rx_busy), 32'd1);
    idle(10);
    UART_RX = 1'b1;
    idle(60);
    check_all("glitch", 1'b0);

    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    m_frame(8'h3C, 1'b1);
    m_frame(8'hC3, 1'b1);
    idle(48);
    check_all("ovr", 1'b0);
    pulse_clear();
    m_clear();
    idle(2);
    check_all("ovr.clr", 1'b0);

    send_frame(8'h55, 1'b0);
    m_frame(8'h55, 1'b0);
    idle(100);
    check_all("ferr", 1'b0);
    fork
      send_frame(8'h12, 1'b1);
      begin
        idle(610);
        pulse_clear();
      end
    join
    m_clear();
    m_frame(8'h12, 1'b1);
    idle(48);
    check_all("ferr.coinc", 1'b0);

    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(BIT * 5);
        reset = 1'b0;
        idle(3);
        chk("midrst.busy", 32'(rx_busy), 32'd0);
        chk("midrst.valid", 32'(rx_valid), 32'd0);
        reset = 1'b1;
      end
    join
    m_reset();
    idle(48);
    send_frame(8'h01, 1'b1);
    m_frame(8'h01, 1'b1);
    idle(48);
    check_all("midrst", 1'b0);

    pulse_clear();
    m_clear();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        pulse_clear();
        m_clear();
      end
      send_frame(b, s);
      m_frame(b, s);
      idle(48);
      check_all($sformatf("rnd%0d", i), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
